// File: rtl/db_multi_fsm.sv
// W-channel debouncer: one four-state FSM per channel driven by a shared 2^N-cycle tick.
// Define DB_SYNC_EN to insert a 2-FF synchronizer on sw ahead of the FSMs (+2 cycles latency).
module db_multi_fsm #(
  parameter int W = 4,
  parameter int N = 20,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] sw,
  output logic [W-1:0] db,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         tick
);

  localparam int CW = $clog2(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t        state [W];
  logic [CW-1:0] cnt   [W];
  logic [N-1:0]  q;
  logic [W-1:0]  s;

`ifdef DB_SYNC_EN
  logic [W-1:0] sw_p0;
  logic [W-1:0] sw_p1;

  // Two-stage synchronizer for asynchronous board inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= sw;
      sw_p1 <= sw_p0;
    end
  end

  assign s = sw_p1;
`else
  assign s = sw;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q + N'(1);
    end
  end

  assign tick = (q == '1);

  // Per-channel FSM; db/rise/fall are set on the same edge as the state change
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < W; i++) begin
        state[i] <= ZERO;
        cnt[i]   <= '0;
      end
      db   <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < W; i++) begin
        case (state[i])
          ZERO: begin
            if (s[i]) begin
              state[i] <= WAIT1;
              cnt[i]   <= '0;
            end
          end
          WAIT1: begin
            // A reversal takes priority over a coincident tick
            if (!s[i]) begin
              state[i] <= ZERO;
            end else if (tick) begin
              if (cnt[i] == CNT_LAST) begin
                state[i] <= ONE;
                db[i]    <= 1'b1;
                rise[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + CW'(1);
              end
            end
          end
          ONE: begin
            if (!s[i]) begin
              state[i] <= WAIT0;
              cnt[i]   <= '0;
            end
          end
          WAIT0: begin
            if (s[i]) begin
              state[i] <= ONE;
            end else if (tick) begin
              if (cnt[i] == CNT_LAST) begin
                state[i] <= ZERO;
                db[i]    <= 1'b0;
                fall[i]  <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + CW'(1);
              end
            end
          end
          default: begin
            state[i] <= ZERO;
            db[i]    <= 1'b0;
            fall[i]  <= db[i];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_db_multi_fsm.sv
// Directed bench for db_multi_fsm with N=4 (tick every 16 cycles), M=3, W=4.
module tb_db_multi_fsm;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int M  = 3;
`ifdef DB_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic         clk;
  logic         reset;
  logic [W-1:0] sw;
  logic [W-1:0] db;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         tick;

  int checks;
  int failures;
  int ecount;

  db_multi_fsm #(.W(W), .N(N), .M(M)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw),
    .db   (db),
    .rise (rise),
    .fall (fall),
    .tick (tick)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1ns after it and inputs driven then too.
  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Ticks are sampled on edges that are multiples of 16 (edge count from release).
  // Acceptance is the 3rd tick edge strictly after the edge that entered WAITx.
  function automatic int accept_edge(input int entry);
    return (entry / 16 + M) * 16;
  endfunction

  task automatic do_reset(input logic [W-1:0] v);
    reset = 1'b1;
    sw    = v;
    repeat (3) step();
    reset  = 1'b0;
    ecount = 0;
  endtask

  task automatic test_reset();
    logic [3*W:0] got;
    reset = 1'b1;
    sw    = 4'hF;
    for (int k = 0; k < 3; k++) begin
      step();
      got = {db, rise, fall, tick};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: got %h want 0", k, got);
      end
    end
    reset  = 1'b0;
    ecount = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      checks++;
      if (tick !== (ecount == 15) || db !== 4'h0) begin
        failures++;
        $display("FAIL first_tick e%0d: got tick=%b db=%h want tick=%b db=0",
                 ecount, tick, db, (ecount == 15));
      end
    end
  endtask

  task automatic test_press();
    int exp_e;
    logic [3*W:0] want;
    logic [3*W:0] got;
    do_reset(4'h0);
    sw    = 4'b0001;
    exp_e = accept_edge(1 + SL);
    for (int k = 0; k < 60; k++) begin
      step();
      want = {(ecount >= exp_e) ? 4'b0001 : 4'b0000,
              (ecount == exp_e) ? 4'b0001 : 4'b0000,
              4'b0000,
              (ecount % 16 == 15)};
      got = {db, rise, fall, tick};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL press e%0d: got db/rise/fall/tick=%h want %h", ecount, got, want);
      end
    end
  endtask

  // Continues from test_press: channel 0 is ONE at edge 60.
  task automatic test_release();
    int exp_e;
    logic [3*W-1:0] want;
    logic [3*W-1:0] got;
    sw    = 4'b0000;
    exp_e = accept_edge(72 + SL);
    while (ecount < 120) begin
      step();
      want = {(ecount < exp_e) ? 4'b0001 : 4'b0000,
              4'b0000,
              (ecount == exp_e) ? 4'b0001 : 4'b0000};
      got = {db, rise, fall};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL release e%0d: got db/rise/fall=%h want %h", ecount, got, want);
      end
      if (ecount == 70) sw[0] = 1'b1;
      else if (ecount == 71) sw[0] = 1'b0;
    end
  endtask

  task automatic test_bounce();
    logic [3*W-1:0] got;
    do_reset(4'h0);
    for (int k = 0; k < 160; k++) begin
      sw[1] = (k < 100) && ((k / 5) % 2 == 0);
      step();
      got = {db, rise, fall};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL bounce k%0d: got db/rise/fall=%h want 0", k, got);
      end
    end
  endtask

  task automatic test_race();
    logic [2*W-1:0] got;
    do_reset(4'h0);
    sw = 4'b0100;
    while (ecount < 70) begin
      step();
      got = {db, rise};
      checks++;
      if (got !== '0) begin
        failures++;
        $display("FAIL race e%0d: got db/rise=%h want 0", ecount, got);
      end
      if (ecount == 47 - SL) sw[2] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [3*W:0] got;
    logic [2*W-1:0] want2;
    logic [2*W-1:0] got2;
    do_reset(4'h0);
    sw = 4'b0001;
    while (ecount < 56) begin
      step();
      if (ecount == 16) sw[3] = 1'b1;
    end
    checks++;
    if (db !== 4'b0001) begin
      failures++;
      $display("FAIL pre_reset_db: got %b want 0001", db);
    end
    reset = 1'b1;
    step();
    got = {db, rise, fall, tick};
    checks++;
    if (got !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got %h want 0", got);
    end
    reset  = 1'b0;
    ecount = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      want2 = {(ecount >= accept_edge(1 + SL)) ? 4'b1001 : 4'b0000,
               (ecount == accept_edge(1 + SL)) ? 4'b1001 : 4'b0000};
      got2  = {db, rise};
      checks++;
      if (got2 !== want2) begin
        failures++;
        $display("FAIL restart e%0d: got db/rise=%h want %h", ecount, got2, want2);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    sw       = '0;
    checks   = 0;
    failures = 0;
    ecount   = 0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
